// File: rtl/bkram_sd_sched.sv
// bkram_sd_sched: schedules backup-RAM sector transfers between nvram and the HPS SD interface.
// Full load / full save always available; dirty-sector autosave is built only when
// the BK_AUTOSAVE_EN macro is defined.
module bkram_sd_sched #(
    parameter int unsigned SECTORS     = 64,
    parameter int unsigned LBA_W       = 6,
    parameter logic [23:0] IDLE_CYCLES = 24'd2000000
) (
    input  logic        clk_sys,
    input  logic        RESET_n,
    input  logic        bk_ena,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        mount_load,
    input  logic        autosave_en,
    input  logic        nvram_we,
    input  logic [14:0] nvram_a,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        busy,
    output logic        loading,
    output logic        dirty
);

    localparam int unsigned SEC_LSB = 9;
    localparam int unsigned CNT_W   = 24;
    localparam logic [LBA_W-1:0] LAST_LBA = LBA_W'(SECTORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_SAVE = 2'd1,
        OP_AUTO = 2'd2
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [LBA_W-1:0]   lba_q, lba_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               busy_q, busy_d;
    logic               loading_q, loading_d;
    logic               dirty_q, dirty_d;
    logic [SECTORS-1:0] bitmap_q, bitmap_d;
    logic               old_load_q, old_load_d;
    logic               old_save_q, old_save_d;
    logic               old_ack_q, old_ack_d;

    logic               load_go_c;
    logic               save_go_c;
    logic               auto_go_c;
    logic               ack_rise_c;
    logic               ack_fall_c;
    logic               xfer_last_c;
    logic [LBA_W-1:0]   next_lba_c;
    logic [LBA_W-1:0]   wr_sector_c;
    logic [SECTORS-1:0] above_c;
    logic               unused_c;

    // Index of the lowest set bit (0 when none set).
    function automatic logic [LBA_W-1:0] lowest_set(input logic [SECTORS-1:0] bm);
        logic [LBA_W-1:0] idx;
        idx = '0;
        for (int i = int'(SECTORS) - 1; i >= 0; i--) begin
            if (bm[i]) idx = LBA_W'(i);
        end
        return idx;
    endfunction

    assign load_go_c   = bk_ena && (mount_load || (load_req && !old_load_q));
    assign save_go_c   = bk_ena && save_req && !old_save_q;
    assign ack_rise_c  = sd_ack && !old_ack_q;
    assign ack_fall_c  = !sd_ack && old_ack_q;
    assign wr_sector_c = nvram_a[SEC_LSB +: LBA_W];

`ifdef BK_AUTOSAVE_EN
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    assign auto_go_c = (idle_cnt_q == IDLE_CYCLES) && autosave_en && bk_ena && (|bitmap_q);
    assign unused_c  = ^nvram_a;
`else
    assign auto_go_c = 1'b0;
    assign unused_c  = ^{autosave_en, IDLE_CYCLES, nvram_a};
`endif

    // Dirty sectors strictly above the current index (autosave successor search).
    always_comb begin
        above_c = '0;
        for (int i = 0; i < int'(SECTORS); i++) begin
            above_c[i] = bitmap_q[i] && (i > int'(lba_q));
        end
    end

    // End-of-operation test and successor sector for the current operation.
    always_comb begin
        if (op_q == OP_AUTO) begin
            xfer_last_c = ~|above_c;
            next_lba_c  = lowest_set(above_c);
        end else begin
            xfer_last_c = (lba_q == LAST_LBA);
            next_lba_c  = lba_q + LBA_W'(1);
        end
    end

    // Next-state and output logic for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lba_d      = lba_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        busy_d     = busy_q;
        loading_d  = loading_q;
        bitmap_d   = bitmap_q;
        old_load_d = load_req;
        old_save_d = save_req;
        old_ack_d  = sd_ack;
`ifdef BK_AUTOSAVE_EN
        if (nvram_we) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_CYCLES) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (load_go_c) begin
                    state_d   = ST_ARM;
                    op_d      = OP_LOAD;
                    lba_d     = '0;
                    rd_d      = 1'b1;
                    busy_d    = 1'b1;
                    loading_d = 1'b1;
                end else if (save_go_c) begin
                    state_d = ST_ARM;
                    op_d    = OP_SAVE;
                    lba_d   = '0;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (auto_go_c) begin
                    state_d = ST_ARM;
                    op_d    = OP_AUTO;
                    lba_d   = lowest_set(bitmap_q);
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
`ifdef BK_AUTOSAVE_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            ST_ARM: begin
                if (ack_rise_c) begin
                    state_d = ST_XFER;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (op_q != OP_LOAD) bitmap_d[lba_q] = 1'b0;
                end
            end
            ST_XFER: begin
                if (ack_fall_c) begin
                    if (xfer_last_c) begin
                        state_d   = ST_IDLE;
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                        if (op_q == OP_LOAD) bitmap_d = '0;
                    end else begin
                        state_d = ST_ARM;
                        lba_d   = next_lba_c;
                        rd_d    = (op_q == OP_LOAD);
                        wr_d    = (op_q != OP_LOAD);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A core write always lands last so it wins over any clear this cycle.
        if (nvram_we) bitmap_d[wr_sector_c] = 1'b1;
        dirty_d = |bitmap_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (!RESET_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_LOAD;
            lba_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            loading_q  <= 1'b0;
            dirty_q    <= 1'b0;
            bitmap_q   <= '0;
            old_load_q <= 1'b0;
            old_save_q <= 1'b0;
            old_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lba_q      <= lba_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            loading_q  <= loading_d;
            dirty_q    <= dirty_d;
            bitmap_q   <= bitmap_d;
            old_load_q <= old_load_d;
            old_save_q <= old_save_d;
            old_ack_q  <= old_ack_d;
        end
    end

`ifdef BK_AUTOSAVE_EN
    // Idle counter register for autosave timing.
    always_ff @(posedge clk_sys) begin
        if (!RESET_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign sd_lba  = {{(32 - LBA_W){1'b0}}, lba_q};
    assign sd_rd   = rd_q;
    assign sd_wr   = wr_q;
    assign busy    = busy_q;
    assign loading = loading_q;
    assign dirty   = dirty_q;

endmodule

// File: tb/tb_bkram_sd_sched.sv
// tb_bkram_sd_sched: directed + randomized bench for bkram_sd_sched with a
// sector-list / dirty-set reference model.
module tb_bkram_sd_sched;

    localparam int unsigned SECT = 64;

    logic        clk_sys = 1'b0;
    logic        RESET_n;
    logic        bk_ena;
    logic        load_req;
    logic        save_req;
    logic        mount_load;
    logic        autosave_en;
    logic        nvram_we;
    logic [14:0] nvram_a;
    logic        sd_ack;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        busy;
    logic        loading;
    logic        dirty;

    int total = 0;
    int bad   = 0;

    bit model_dirty [SECT];
    int exp_q [$];

    bkram_sd_sched #(
        .SECTORS     (64),
        .LBA_W       (6),
        .IDLE_CYCLES (24'd100)
    ) dut (
        .clk_sys     (clk_sys),
        .RESET_n     (RESET_n),
        .bk_ena      (bk_ena),
        .load_req    (load_req),
        .save_req    (save_req),
        .mount_load  (mount_load),
        .autosave_en (autosave_en),
        .nvram_we    (nvram_we),
        .nvram_a     (nvram_a),
        .sd_ack      (sd_ack),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .busy        (busy),
        .loading     (loading),
        .dirty       (dirty)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_any();
        bit a = 1'b0;
        for (int i = 0; i < int'(SECT); i++) a |= model_dirty[i];
        return a;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(SECT); i++) model_dirty[i] = 1'b0;
    endtask

    // Expected order for full load / full save.
    task automatic fill_full();
        exp_q.delete();
        for (int i = 0; i < int'(SECT); i++) exp_q.push_back(i);
    endtask

    // Expected order for autosave: dirty sectors ascending.
    task automatic fill_dirty();
        exp_q.delete();
        for (int i = 0; i < int'(SECT); i++) if (model_dirty[i]) exp_q.push_back(i);
    endtask

    task automatic nv_write(input logic [14:0] a);
        nvram_we = 1'b1;
        nvram_a  = a;
        @(negedge clk_sys);
        nvram_we = 1'b0;
        model_dirty[a[14:9]] = 1'b1;
    endtask

    task automatic idle_check(input string tag, input int n);
        bit any = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr || busy) any = 1'b1;
        end
        check(tag, 32'(any), 32'd0);
    endtask

    // Acts as the HPS side for every sector in exp_q.
    task automatic serve_op(input bit is_rd, input bit rand_wr, input int poke_at,
                            input int abort_at, input int wr_at_lba);
        bit seen;
        int hold;
        for (int s = 0; s < exp_q.size(); s++) begin
            seen = 1'b0;
            for (int k = 0; k < 400 && !seen; k++) begin
                @(negedge clk_sys);
                if (sd_rd || sd_wr) seen = 1'b1;
            end
            check("req_seen", 32'(seen), 32'd1);
            if (!seen) return;
            check("req_lba", sd_lba, 32'(exp_q[s]));
            check("req_rd", 32'(sd_rd), 32'(is_rd));
            check("req_wr", 32'(sd_wr), 32'(!is_rd));
            check("req_busy", 32'(busy), 32'd1);
            check("req_loading", 32'(loading), 32'(is_rd));
            if (s == abort_at) begin
                RESET_n = 1'b0;
                @(negedge clk_sys);
                check("rst_wr", 32'(sd_wr), 32'd0);
                check("rst_rd", 32'(sd_rd), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_lba", sd_lba, 32'd0);
                check("rst_dirty", 32'(dirty), 32'd0);
                model_clear();
                save_req = 1'b0;
                load_req = 1'b0;
                @(negedge clk_sys);
                RESET_n = 1'b1;
                return;
            end
            if (s == poke_at) load_req = 1'b1;
            repeat ($urandom_range(0, 4)) @(negedge clk_sys);
            sd_ack = 1'b1;
            if (!is_rd) model_dirty[exp_q[s]] = 1'b0;
            @(negedge clk_sys);
            check("req_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
            hold = $urandom_range(1, 20);
            for (int h = 0; h < hold; h++) begin
                if (h == 0 && (exp_q[s] == wr_at_lba ||
                               (rand_wr && $urandom_range(0, 3) == 0))) begin
                    nvram_we = 1'b1;
                    nvram_a  = {6'(exp_q[s]), 9'h010};
                    model_dirty[exp_q[s]] = 1'b1;
                end
                @(negedge clk_sys);
                nvram_we = 1'b0;
            end
            sd_ack = 1'b0;
        end
        @(negedge clk_sys);
        check("end_busy", 32'(busy), 32'd0);
        check("end_loading", 32'(loading), 32'd0);
        check("end_req", {30'd0, sd_rd, sd_wr}, 32'd0);
        if (is_rd) model_clear();
    endtask

    initial begin
        RESET_n     = 1'b0;
        bk_ena      = 1'b0;
        load_req    = 1'b0;
        save_req    = 1'b0;
        mount_load  = 1'b0;
        autosave_en = 1'b0;
        nvram_we    = 1'b0;
        nvram_a     = '0;
        sd_ack      = 1'b0;
        model_clear();
        repeat (3) @(negedge clk_sys);
        check("reset_lba", sd_lba, 32'd0);
        check("reset_rd", 32'(sd_rd), 32'd0);
        check("reset_wr", 32'(sd_wr), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_loading", 32'(loading), 32'd0);
        check("reset_dirty", 32'(dirty), 32'd0);
        RESET_n = 1'b1;
        @(negedge clk_sys);

        // Random core writes mark sectors dirty.
        for (int i = 0; i < 6; i++) nv_write(15'($urandom));
        check("dirty_after_wr", 32'(dirty), 32'(model_any()));

        // No image mounted: save edge must not start anything.
        save_req = 1'b1;
        idle_check("no_save_bk_off", 1000);
        save_req = 1'b0;
        bk_ena   = 1'b1;
        @(negedge clk_sys);

        // Full load.
        load_req = 1'b1;
        fill_full();
        serve_op(1'b1, 1'b0, -1, -1, -1);
        check("dirty_after_load", 32'(dirty), 32'(model_any()));
        load_req = 1'b0;
        @(negedge clk_sys);

        // Load and save edges together: load wins, save lost.
        load_req = 1'b1;
        save_req = 1'b1;
        fill_full();
        serve_op(1'b1, 1'b0, -1, -1, -1);
        idle_check("save_edge_lost", 50);
        load_req = 1'b0;
        save_req = 1'b0;
        @(negedge clk_sys);

        // Full save with writes behind acked sectors and a load edge while busy.
        for (int i = 0; i < 6; i++) nv_write(15'($urandom));
        check("dirty_before_save", 32'(dirty), 32'd1);
        save_req = 1'b1;
        fill_full();
        serve_op(1'b0, 1'b1, 5, -1, -1);
        check("dirty_after_save", 32'(dirty), 32'(model_any()));
        idle_check("busy_edge_ignored", 50);
        load_req = 1'b0;
        save_req = 1'b0;
        @(negedge clk_sys);

        // Mount-triggered load.
        mount_load = 1'b1;
        @(negedge clk_sys);
        mount_load = 1'b0;
        fill_full();
        serve_op(1'b1, 1'b0, -1, -1, -1);
        check("dirty_after_mount", 32'(dirty), 32'(model_any()));

        // Reset in the middle of a full save.
        for (int i = 0; i < 3; i++) nv_write(15'($urandom));
        save_req = 1'b1;
        fill_full();
        serve_op(1'b0, 1'b0, -1, 10, -1);
        idle_check("post_reset_idle", 50);

`ifdef BK_AUTOSAVE_EN
        // Autosave of two dirty sectors, with sector 2 re-dirtied mid-pass.
        autosave_en = 1'b1;
        nv_write(15'h0400);
        nv_write(15'h7E00);
        fill_dirty();
        serve_op(1'b0, 1'b0, -1, -1, 2);
        check("dirty_after_auto1", 32'(dirty), 32'(model_any()));
        fill_dirty();
        serve_op(1'b0, 1'b0, -1, -1, -1);
        check("dirty_after_auto2", 32'(dirty), 32'(model_any()));
        autosave_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
